// File: rtl/cp0_ex_ctrl_pkg.sv
// Shared CP0 definitions: register addresses, exception codes, FSM encoding
// and the exception-flag payload handed from WB to the priority encoder.
package cp0_ex_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned EXCODE_W   = 5;
  localparam int unsigned CP0_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_COUNT    = 5'd9;
  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_COMPARE  = 5'd11;
  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_STATUS   = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [CP0_ADDR_W-1:0] CP0_ADDR_EPC      = 5'd14;

  localparam logic [EXCODE_W-1:0] EXCODE_INT  = 5'h00;
  localparam logic [EXCODE_W-1:0] EXCODE_ADEL = 5'h04;
  localparam logic [EXCODE_W-1:0] EXCODE_ADES = 5'h05;
  localparam logic [EXCODE_W-1:0] EXCODE_SYS  = 5'h08;
  localparam logic [EXCODE_W-1:0] EXCODE_BP   = 5'h09;
  localparam logic [EXCODE_W-1:0] EXCODE_RI   = 5'h0a;
  localparam logic [EXCODE_W-1:0] EXCODE_OV   = 5'h0c;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // Fields listed highest priority first.
  typedef struct packed {
    logic int_req;
    logic adel_if;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel;
    logic ades;
  } ex_flags_t;

endpackage

// File: rtl/cp0_ex_ctrl_ex_prio_enc.sv
// Combinational priority encoder: WB exception flags -> has_ex and excode.
module ex_prio_enc
  import cp0_ex_ctrl_pkg::*;
(
  input  ex_flags_t             flags,
  output logic                  has_ex_c,
  output logic [EXCODE_W-1:0]   excode_c
);

  always_comb begin
    has_ex_c = |flags;
    excode_c = EXCODE_INT;
    if (flags.int_req)      excode_c = EXCODE_INT;
    else if (flags.adel_if) excode_c = EXCODE_ADEL;
    else if (flags.ri)      excode_c = EXCODE_RI;
    else if (flags.ov)      excode_c = EXCODE_OV;
    else if (flags.sys)     excode_c = EXCODE_SYS;
    else if (flags.bp)      excode_c = EXCODE_BP;
    else if (flags.adel)    excode_c = EXCODE_ADEL;
    else if (flags.ades)    excode_c = EXCODE_ADES;
  end

endmodule

// File: rtl/cp0_ex_ctrl.sv
// WB-boundary exception/ERET commit toward CP0, followed by a pipeline flush
// and a valid/ready PC redirect toward fetch.
module cp0_ex_ctrl
  import cp0_ex_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] EX_ENTRY     = 32'hbfc00380,
  parameter int unsigned     FLUSH_CYCLES = 2
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_valid,
  input  logic [XLEN-1:0]      ws_pc,
  input  logic                 ws_bd,
  input  logic                 ws_ex_adel_if,
  input  logic                 ws_ex_ri,
  input  logic                 ws_ex_ov,
  input  logic                 ws_ex_sys,
  input  logic                 ws_ex_bp,
  input  logic                 ws_ex_adel,
  input  logic                 ws_ex_ades,
  input  logic                 ws_eret,
  input  logic                 int_req,
  input  logic [XLEN-1:0]      cp0_epc,
  output logic                 cp0_ex,
  output logic [EXCODE_W-1:0]  cp0_excode,
  output logic                 cp0_bd,
  output logic [XLEN-1:0]      cp0_wdata,
  output logic                 cp0_eret,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 redirect_ready,
  output logic                 busy
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  ex_flags_t             flags;
  logic                  has_ex_c;
  logic [EXCODE_W-1:0]   excode_c;
  logic                  evt_ex, evt_eret;

  logic                  cp0_ex_q, cp0_ex_d;
  logic [EXCODE_W-1:0]   cp0_excode_q, cp0_excode_d;
  logic                  cp0_bd_q, cp0_bd_d;
  logic [XLEN-1:0]       cp0_wdata_q, cp0_wdata_d;
  logic                  cp0_eret_q, cp0_eret_d;
  logic                  flush_q, flush_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  busy_q, busy_d;

  assign flags = '{int_req: int_req,       adel_if: ws_ex_adel_if,
                   ri:      ws_ex_ri,      ov:      ws_ex_ov,
                   sys:     ws_ex_sys,     bp:      ws_ex_bp,
                   adel:    ws_ex_adel,    ades:    ws_ex_ades};

  ex_prio_enc u_prio (
    .flags    (flags),
    .has_ex_c (has_ex_c),
    .excode_c (excode_c)
  );

  // Events only count in IDLE; an exception wins over ERET on the same instruction.
  assign evt_ex   = (state_q == ST_IDLE) & ws_valid & has_ex_c;
  assign evt_eret = (state_q == ST_IDLE) & ws_valid & ws_eret & ~has_ex_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      cp0_ex_q         <= 1'b0;
      cp0_excode_q     <= '0;
      cp0_bd_q         <= 1'b0;
      cp0_wdata_q      <= '0;
      cp0_eret_q       <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cp0_ex_q         <= cp0_ex_d;
      cp0_excode_q     <= cp0_excode_d;
      cp0_bd_q         <= cp0_bd_d;
      cp0_wdata_q      <= cp0_wdata_d;
      cp0_eret_q       <= cp0_eret_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  // Next state and flush counter; counter holds the remaining FLUSH cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt_ex || evt_eret) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        state_d = (FLUSH_CYCLES == 1) ? ST_REDIRECT : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        if (redirect_valid_q && redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    cp0_ex_d         = 1'b0;
    cp0_eret_d       = 1'b0;
    cp0_excode_d     = cp0_excode_q;
    cp0_bd_d         = cp0_bd_q;
    cp0_wdata_d      = cp0_wdata_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = (state_d == ST_COMMIT) || (state_d == ST_FLUSH);
    redirect_valid_d = (state_d == ST_REDIRECT);
    busy_d           = (state_d != ST_IDLE);
    if (evt_ex || evt_eret) begin
      cp0_ex_d      = evt_ex;
      cp0_eret_d    = evt_eret;
      cp0_excode_d  = excode_c;
      cp0_bd_d      = ws_bd;
      cp0_wdata_d   = ws_pc;
      redirect_pc_d = evt_ex ? EX_ENTRY : cp0_epc;
    end
  end

  assign cp0_ex         = cp0_ex_q;
  assign cp0_excode     = cp0_excode_q;
  assign cp0_bd         = cp0_bd_q;
  assign cp0_wdata      = cp0_wdata_q;
  assign cp0_eret       = cp0_eret_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cp0_ex_ctrl.sv
// Bench for cp0_ex_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-count model of the commit/flush/redirect sequence.
module tb_cp0_ex_ctrl;

  localparam int unsigned FC  = 2;
  localparam logic [31:0] EXV = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_bd, ws_eret, int_req;
  logic [31:0] ws_pc, cp0_epc;
  logic        ws_ex_adel_if, ws_ex_ri, ws_ex_ov, ws_ex_sys, ws_ex_bp, ws_ex_adel, ws_ex_ades;
  logic        cp0_ex, cp0_bd, cp0_eret, flush, redirect_valid, redirect_ready, busy;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_wdata, redirect_pc;

  int n_checks = 0;
  int n_pass   = 0;

  cp0_ex_ctrl #(.EX_ENTRY(EXV), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .ws_ex_adel_if(ws_ex_adel_if), .ws_ex_ri(ws_ex_ri), .ws_ex_ov(ws_ex_ov),
    .ws_ex_sys(ws_ex_sys), .ws_ex_bp(ws_ex_bp), .ws_ex_adel(ws_ex_adel),
    .ws_ex_ades(ws_ex_ades), .ws_eret(ws_eret), .int_req(int_req), .cp0_epc(cp0_epc),
    .cp0_ex(cp0_ex), .cp0_excode(cp0_excode), .cp0_bd(cp0_bd), .cp0_wdata(cp0_wdata),
    .cp0_eret(cp0_eret), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ws();
    ws_valid = 0; ws_pc = '0; ws_bd = 0; ws_eret = 0; int_req = 0;
    ws_ex_adel_if = 0; ws_ex_ri = 0; ws_ex_ov = 0; ws_ex_sys = 0;
    ws_ex_bp = 0; ws_ex_adel = 0; ws_ex_ades = 0;
  endtask

  // Bounded wait for redirect_valid, then a one-cycle handshake back to idle.
  task automatic wait_redirect(input string name);
    int k = 0;
    while (redirect_valid !== 1'b1 && k < 20) begin tick(); k++; end
    n_checks++;
    if (redirect_valid !== 1'b1) $display("FAIL %s_timeout redirect_valid=%0b exp 1", name, redirect_valid);
    else n_pass++;
    redirect_ready = 1; tick(); redirect_ready = 0;
    n_checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0)
      $display("FAIL %s_idle busy=%0b rv=%0b exp 0 0", name, busy, redirect_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1; redirect_ready = 0; cp0_epc = '0; clear_ws();
    tick(); tick();
    n_checks++;
    if ({cp0_ex, cp0_excode, cp0_bd, cp0_wdata, cp0_eret, flush, redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL reset_outputs ex=%0b code=%h wdata=%h eret=%0b flush=%0b rv=%0b rpc=%h busy=%0b exp all 0",
               cp0_ex, cp0_excode, cp0_wdata, cp0_eret, flush, redirect_valid, redirect_pc, busy);
    else n_pass++;
    reset = 0; tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release busy=%0b exp 0", busy); else n_pass++;
  endtask

  task automatic test_valid_low();
    ws_valid = 0; ws_ex_ov = 1; ws_ex_sys = 1; int_req = 1; ws_eret = 1;
    tick(); tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || cp0_ex !== 1'b0 || cp0_eret !== 1'b0)
      $display("FAIL valid_low busy=%0b ex=%0b eret=%0b exp 0 0 0", busy, cp0_ex, cp0_eret);
    else n_pass++;
    clear_ws();
  endtask

  task automatic test_overflow();
    ws_valid = 1; ws_ex_ov = 1; ws_pc = 32'hbfc00100; ws_bd = 0;
    tick(); clear_ws();
    n_checks++;
    if (cp0_ex !== 1'b1 || cp0_excode !== 5'h0c || cp0_wdata !== 32'hbfc00100 || cp0_bd !== 1'b0 ||
        flush !== 1'b1 || redirect_valid !== 1'b0 || cp0_eret !== 1'b0)
      $display("FAIL ov_commit ex=%0b code=%h wdata=%h bd=%0b flush=%0b rv=%0b exp 1 0c bfc00100 0 1 0",
               cp0_ex, cp0_excode, cp0_wdata, cp0_bd, flush, redirect_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (cp0_ex !== 1'b0 || flush !== 1'b1 || redirect_valid !== 1'b0)
      $display("FAIL ov_flush2 ex=%0b flush=%0b rv=%0b exp 0 1 0", cp0_ex, flush, redirect_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== EXV || cp0_excode !== 5'h0c)
      $display("FAIL ov_redirect flush=%0b rv=%0b rpc=%h code=%h exp 0 1 %h 0c",
               flush, redirect_valid, redirect_pc, cp0_excode, EXV);
    else n_pass++;
    redirect_ready = 1; tick(); redirect_ready = 0;
    n_checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ov_done rv=%0b busy=%0b exp 0 0", redirect_valid, busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    ws_valid = 1; ws_ex_adel_if = 1; ws_ex_ri = 1; int_req = 1; ws_bd = 1; ws_pc = 32'hbfc00204;
    tick(); clear_ws();
    n_checks++;
    if (cp0_ex !== 1'b1 || cp0_excode !== 5'h00 || cp0_bd !== 1'b1 || cp0_wdata !== 32'hbfc00204)
      $display("FAIL prio_int ex=%0b code=%h bd=%0b wdata=%h exp 1 00 1 bfc00204",
               cp0_ex, cp0_excode, cp0_bd, cp0_wdata);
    else n_pass++;
    wait_redirect("prio_int");
    ws_valid = 1; ws_ex_ri = 1; ws_ex_ades = 1; ws_ex_bp = 1; ws_pc = 32'h00400010;
    tick(); clear_ws();
    n_checks++;
    if (cp0_excode !== 5'h0a || cp0_bd !== 1'b0)
      $display("FAIL prio_ri code=%h bd=%0b exp 0a 0", cp0_excode, cp0_bd);
    else n_pass++;
    wait_redirect("prio_ri");
  endtask

  task automatic test_eret();
    ws_valid = 1; ws_eret = 1; cp0_epc = 32'hbfc00660;
    tick(); clear_ws(); cp0_epc = 32'h12345678;
    n_checks++;
    if (cp0_eret !== 1'b1 || cp0_ex !== 1'b0 || flush !== 1'b1)
      $display("FAIL eret_commit eret=%0b ex=%0b flush=%0b exp 1 0 1", cp0_eret, cp0_ex, flush);
    else n_pass++;
    tick();
    n_checks++;
    if (cp0_eret !== 1'b0) $display("FAIL eret_pulse eret=%0b exp 0", cp0_eret); else n_pass++;
    tick();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hbfc00660)
      $display("FAIL eret_target rv=%0b rpc=%h exp 1 bfc00660", redirect_valid, redirect_pc);
    else n_pass++;
    wait_redirect("eret");
  endtask

  task automatic test_eret_vs_sys();
    logic seen_eret = 1'b0;
    int k = 0;
    ws_valid = 1; ws_eret = 1; ws_ex_sys = 1; ws_pc = 32'hbfc00300; cp0_epc = 32'hbfc00660;
    tick(); clear_ws();
    n_checks++;
    if (cp0_ex !== 1'b1 || cp0_excode !== 5'h08 || cp0_eret !== 1'b0)
      $display("FAIL sys_eret ex=%0b code=%h eret=%0b exp 1 08 0", cp0_ex, cp0_excode, cp0_eret);
    else n_pass++;
    while (redirect_valid !== 1'b1 && k < 20) begin
      tick(); k++;
      seen_eret = seen_eret | (cp0_eret === 1'b1);
    end
    n_checks++;
    if (seen_eret !== 1'b0 || redirect_pc !== EXV)
      $display("FAIL sys_eret_seq seen_eret=%0b rpc=%h exp 0 %h", seen_eret, redirect_pc, EXV);
    else n_pass++;
    wait_redirect("sys_eret");
  endtask

  task automatic test_back_to_back_stall();
    int k = 0;
    ws_valid = 1; ws_ex_ov = 1; ws_pc = 32'hbfc00500;
    tick(); clear_ws();
    while (redirect_valid !== 1'b1 && k < 20) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      ws_valid = 1; ws_ex_bp = 1; ws_pc = $urandom;
      tick();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== EXV || cp0_ex !== 1'b0 || flush !== 1'b0 ||
          cp0_excode !== 5'h0c || cp0_wdata !== 32'hbfc00500)
        $display("FAIL stall_%0d rv=%0b rpc=%h ex=%0b flush=%0b code=%h wdata=%h exp 1 %h 0 0 0c bfc00500",
                 i, redirect_valid, redirect_pc, cp0_ex, flush, cp0_excode, cp0_wdata, EXV);
      else n_pass++;
    end
    clear_ws(); redirect_ready = 1; tick(); redirect_ready = 0;
    n_checks++;
    if (redirect_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_done rv=%0b busy=%0b exp 0 0", redirect_valid, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (cp0_ex !== 1'b0 || busy !== 1'b0)
      $display("FAIL stall_no_replay ex=%0b busy=%0b exp 0 0", cp0_ex, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    ws_valid = 1; ws_ex_ov = 1; ws_pc = 32'hbfc00700;
    tick(); clear_ws();
    tick();
    n_checks++;
    if (flush !== 1'b1) $display("FAIL rst_pre_flush flush=%0b exp 1", flush); else n_pass++;
    #1 reset = 1;
    #1;
    n_checks++;
    if ({cp0_ex, cp0_excode, cp0_bd, cp0_wdata, cp0_eret, flush, redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL rst_async flush=%0b rv=%0b rpc=%h busy=%0b wdata=%h exp all 0",
               flush, redirect_valid, redirect_pc, busy, cp0_wdata);
    else n_pass++;
    tick(); reset = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0 || cp0_ex !== 1'b0 || flush !== 1'b0)
        $display("FAIL rst_quiet_%0d rv=%0b busy=%0b ex=%0b flush=%0b exp 0 0 0 0",
                 i, redirect_valid, busy, cp0_ex, flush);
      else n_pass++;
    end
    ws_valid = 1; ws_ex_sys = 1; ws_pc = 32'hbfc00800;
    tick(); clear_ws();
    n_checks++;
    if (cp0_ex !== 1'b1 || cp0_excode !== 5'h08)
      $display("FAIL rst_new_event ex=%0b code=%h exp 1 08", cp0_ex, cp0_excode);
    else n_pass++;
    wait_redirect("rst_new");
  endtask

  // Model: a busy sequence is just a cycle count t since commit (t=1 commit,
  // t<=FC flushing, t>FC offering redirect until accepted).
  task automatic test_random();
    bit          m_busy = 0, m_is_ex = 0, m_last_ex = 0;
    int          m_t = 0;
    logic [4:0]  m_code = '0;
    logic        m_bd = 0;
    logic [31:0] m_wdata = '0, m_target = '0;
    bit          fl[8];
    logic [4:0]  codes[8];
    bit          any_ex;
    logic [4:0]  code;
    bit          e_ex, e_eret, e_flush, e_rv;
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    for (int c = 0; c < 600; c++) begin
      ws_valid = ($urandom_range(0, 99) < 60);
      int_req = ($urandom_range(0, 99) < 8);
      ws_ex_adel_if = ($urandom_range(0, 99) < 8);
      ws_ex_ri = ($urandom_range(0, 99) < 8);
      ws_ex_ov = ($urandom_range(0, 99) < 8);
      ws_ex_sys = ($urandom_range(0, 99) < 8);
      ws_ex_bp = ($urandom_range(0, 99) < 8);
      ws_ex_adel = ($urandom_range(0, 99) < 8);
      ws_ex_ades = ($urandom_range(0, 99) < 8);
      ws_eret = ($urandom_range(0, 99) < 25);
      ws_bd = 1'($urandom_range(0, 1));
      ws_pc = $urandom; cp0_epc = $urandom;
      redirect_ready = ($urandom_range(0, 99) < 40);
      fl = '{int_req, ws_ex_adel_if, ws_ex_ri, ws_ex_ov, ws_ex_sys, ws_ex_bp, ws_ex_adel, ws_ex_ades};
      any_ex = 0; code = '0;
      for (int j = 7; j >= 0; j--) if (fl[j]) begin any_ex = 1; code = codes[j]; end
      if (m_busy) begin
        if (m_t > FC && redirect_ready) m_busy = 0;
        else m_t++;
      end else if (ws_valid && (any_ex || ws_eret)) begin
        m_busy = 1; m_t = 1; m_is_ex = any_ex;
        m_target = any_ex ? EXV : cp0_epc;
        if (any_ex) begin m_code = code; m_bd = ws_bd; m_wdata = ws_pc; end
        m_last_ex = any_ex;
      end
      tick();
      e_ex = m_busy && m_t == 1 && m_is_ex;
      e_eret = m_busy && m_t == 1 && !m_is_ex;
      e_flush = m_busy && m_t <= FC;
      e_rv = m_busy && m_t > FC;
      n_checks++;
      if ({cp0_ex, cp0_eret, flush, redirect_valid, busy} !== {e_ex, e_eret, e_flush, e_rv, m_busy})
        $display("FAIL rnd_ctrl_%0d ex/eret/flush/rv/busy=%b exp %b", c,
                 {cp0_ex, cp0_eret, flush, redirect_valid, busy}, {e_ex, e_eret, e_flush, e_rv, m_busy});
      else n_pass++;
      if (e_rv) begin
        n_checks++;
        if (redirect_pc !== m_target) $display("FAIL rnd_rpc_%0d rpc=%h exp %h", c, redirect_pc, m_target);
        else n_pass++;
      end
      if (m_last_ex) begin
        n_checks++;
        if (cp0_excode !== m_code || cp0_bd !== m_bd || cp0_wdata !== m_wdata)
          $display("FAIL rnd_fields_%0d code=%h bd=%0b wdata=%h exp %h %0b %h",
                   c, cp0_excode, cp0_bd, cp0_wdata, m_code, m_bd, m_wdata);
        else n_pass++;
      end
    end
    clear_ws(); redirect_ready = 1; tick(); tick(); tick(); tick(); redirect_ready = 0;
  endtask

  initial begin
    test_reset();
    test_valid_low();
    test_overflow();
    test_priority();
    test_eret();
    test_eret_vs_sys();
    test_back_to_back_stall();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
